// File: rtl/bcd2binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One shift/correct step per clock, BIN_W steps per conversion, start/hold handshake.
module bcd2binary #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   a,
    output logic [BIN_W-1:0]      b,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               a_invalid;
    logic [WORK_W-1:0]  work_sh;
    logic [BCD_W-1:0]   bcd_fix;

    always_comb begin
        a_invalid = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9) begin
                a_invalid = 1'b1;
            end
        end
    end

    // Shift first, then correct each digit of the shifted BCD field on its own.
    always_comb begin
        work_sh = {bcd_q, bin_q} >> 1;
        bcd_fix = work_sh[WORK_W-1 -: BCD_W];
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_fix[4*i +: 4] >= 4'd8) begin
                bcd_fix[4*i +: 4] = bcd_fix[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    bcd_d = a;
                    bin_d = '0;
                    cnt_d = '0;
                    if (a_invalid) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bcd_d = bcd_fix;
                bin_d = work_sh[BIN_W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    b_d     = work_sh[BIN_W-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign b    = b_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd2binary.sv
// Directed self-checking bench for bcd2binary (DIGITS=3, BIN_W=10).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bcd2binary;

    localparam int unsigned DIGITS = 3;
    localparam int unsigned BIN_W  = 10;
    localparam int LAT = BIN_W + 1;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [11:0]       a;
    logic [BIN_W-1:0]  b;
    logic              busy;
    logic              done;
    logic              err;

    int checks;
    int errors;

    bcd2binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Pulses en for one edge, then follows the conversion until done or a cycle budget runs out.
    task automatic run_conv(input string tag, input logic [11:0] val,
                            input int exp_b, input logic exp_err, input int exp_lat);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        a  = val;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
        check({tag, "_b"}, b, exp_b);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int done_cnt;
        int pulses[$];
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        a     = '0;
        repeat (3) @(negedge clk);
        check("reset_b", b, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        rst_n = 1'b1;

        run_conv("c999", 12'h999, 999, 1'b0, LAT);
        run_conv("c000", 12'h000, 0, 1'b0, LAT);
        run_conv("c255", 12'h255, 255, 1'b0, LAT);
        run_conv("c1A3", 12'h1A3, 255, 1'b1, 1);
        run_conv("c042", 12'h042, 42, 1'b0, LAT);
        run_conv("c908", 12'h908, 908, 1'b0, LAT);
        run_conv("cF00", 12'hF00, 908, 1'b1, 1);

        // en re-pulsed mid-conversion and at the completion edge must be ignored
        @(negedge clk);
        a  = 12'h500;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        a  = 12'h111;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (6) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("ign_done", done, 1);
        check("ign_b", b, 500);
        check("ign_busy_at_done", busy, 0);
        @(negedge clk);
        check("ign_no_restart", busy, 0);
        check("ign_done_low", done, 0);
        run_conv("c111", 12'h111, 111, 1'b0, LAT);

        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        a  = 12'h876;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_b", b, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);
        check("rst_idle", busy, 0);
        run_conv("c876", 12'h876, 876, 1'b0, LAT);

        // en held high: a conversion restarts on the edge after each done
        @(negedge clk);
        a  = 12'h007;
        en = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (done) pulses.push_back(c);
        end
        en = 1'b0;
        check("hold_pulse_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("hold_first", pulses[0], LAT);
            check("hold_period1", pulses[1] - pulses[0], LAT);
            check("hold_period2", pulses[2] - pulses[1], LAT);
        end
        check("hold_b", b, 7);
        begin
            int guard;
            guard = 0;
            while (busy && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            check("hold_drain_timeout", (guard < 40) ? 1 : 0, 1);
        end
        @(negedge clk);
        check("hold_final_b", b, 7);
        check("hold_final_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd2binary.md
Name: bcd2binary

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3 from each digit that is 8 or more).
- The inverse of the team's binary2bcd block.
- Converts packed BCD, such as keypad-entered decimal operands, into binary for the gcd datapath.
- Has the same start/hold handshake style as binary2bcd.

Parameters:
- DIGITS, 3, number of packed BCD digits at input a (a width = 4*DIGITS).
- BIN_W, 10, binary output width. Must satisfy 2^BIN_W > 10^DIGITS - 1; the default covers 0..999. Also sets the iteration count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  start request; sampled only in IDLE.
- a  input  4*DIGITS  packed BCD operand; a[3:0] is the least significant digit.
- b  output  BIN_W  binary result; held until the next successful conversion.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  the last accepted operand contained a digit greater than 9.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; b=0, busy=0, done=0, err=0.
  - Shift register and iteration counter cleared.
  - Takes effect immediately, including mid-conversion. No done pulse follows a reset.
- States: IDLE, SHIFT.
- IDLE, edge T0 with en=1:
  - a is captured into the BCD field of the work register {bcd[4*DIGITS-1:0], bin[BIN_W-1:0]}; bin=0, counter=0.
  - err is cleared.
  - If any digit of a is greater than 9: stay in IDLE, set err=1, pulse done at T0 (visible in cycle T0..T0+1), leave b unchanged, busy stays 0.
  - Otherwise: go to SHIFT, busy=1.
- SHIFT, each edge:
  - Shift the whole work register right by 1; the LSB of bcd enters the MSB of bin.
  - Then, for each 4-bit digit of the shifted bcd field independently: if the digit is 8 or more, subtract 3.
  - Counter increments.
- Completion:
  - On the BIN_W-th SHIFT edge (T0+BIN_W), b is loaded with the final bin value.
  - At the same edge: done=1 for exactly one cycle, busy=0, return to IDLE.
  - Latency: done is high in the cycle following edge T0+BIN_W. The bcd field is zero at that point for any valid input.
- Handshake:
  - en is ignored while busy=1, including at the completion edge.
  - en may be level or pulse; holding it high restarts a conversion on each IDLE cycle.
  - Back-to-back: an en sampled on the edge right after done rises starts a new conversion.
  - a is not required to be stable after T0.
- Held outputs:
  - b and err hold between conversions.
  - b is unaffected by an err conversion.
  - done is never high for two consecutive cycles unless back-to-back err conversions occur.
- Widths:
  - Digit correction uses 4-bit unsigned subtraction; no carry between digits.
  - The counter is wide enough to hold BIN_W.

Test Plan:
- Reset, then en pulse with a=12'h999 -> busy high 10 cycles; done pulses at T0+10; b=10'd999 (0x3E7); err=0.
- a=12'h000, then a=12'h255 sequentially -> b=0, then b=255; each done exactly one cycle; latency 10 each time.
- a=12'h1A3 -> done the cycle after T0; err=1; busy never asserts; b keeps its prior value (255). A following a=12'h042 -> err=0, b=42.
- en re-pulsed at T0+3 and at T0+10 with a=12'h111 while converting 12'h500 -> both ignored; b=500. A later en with 12'h111 -> b=111.
- rst_n low at T0+5 of a 12'h876 conversion -> b=0, busy=0, done=0 immediately; no done afterwards. A new conversion of 12'h876 -> b=876.
- en held high continuously with a=12'h007 -> a conversion restarts on the edge after each done; done pulses every 11 cycles; b=7.
